ftq: RTL and testbench

- Fetch Target Queue: the circular buffer at the other end of the BPU's prediction interface.
- Accepts P0 next-line blocks and P1 main-predictor overrides from the BPU.
- Issues fetch blocks in order to the IFU.
- On backend commit, returns one training record per block to the BPU (ftq_bpu_meta_t).
- Exerts back-pressure on the BPU through ftq_full_o.

---
 rtl/ftq_pkg.sv | 64 ++++++
 rtl/ftq_entry_ram.sv | 39 +++
 rtl/ftq.sv | 184 ++++++++++++++++++
 tb/tb_ftq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftq_pkg.sv
// Fetch Target Queue shared types: fetch blocks, predictor meta, commit info and training record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ftq_pkg;

   localparam int unsigned FTQ_DEPTH  = 8;
   localparam int unsigned FTQ_ID_W   = $clog2(FTQ_DEPTH);
   localparam int unsigned PC_W       = 32;
   localparam int unsigned FTB_IDX_W  = 4;
   localparam int unsigned BPU_META_W = 16;

   // Pointer with one extra wrap bit above the entry index.
   typedef logic [FTQ_ID_W:0] ftq_ptr_t;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_COND = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } branch_type_e;

   // One fetch block as predicted by the BPU.
   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] start_pc;
      logic [3:0]      length;
      logic            predict_valid;
      logic            predicted_taken;
      logic            is_cross_cacheline;
   } ftq_block_t;

   // Main-predictor meta delivered alongside a P1 override.
   typedef struct packed {
      logic                  ftb_hit;
      logic [FTB_IDX_W-1:0]  ftb_hit_index;
      logic [BPU_META_W-1:0] bpu_meta;
   } bpu_ftq_meta_t;

   // Resolved branch information from the backend.
   typedef struct packed {
      logic            is_taken;
      branch_type_e    branch_type;
      logic [PC_W-1:0] jump_target_address;
      logic [PC_W-1:0] fall_through_address;
      logic            ftb_dirty;
   } ftq_commit_t;

   // Training record returned to the BPU after a block commits.
   typedef struct packed {
      logic                  valid;
      logic [PC_W-1:0]       start_pc;
      logic                  is_cross_cacheline;
      logic                  predicted_taken;
      logic [BPU_META_W-1:0] bpu_meta;
      logic                  is_taken;
      branch_type_e          branch_type;
      logic [PC_W-1:0]       jump_target_address;
      logic [PC_W-1:0]       fall_through_address;
      logic                  ftb_dirty;
      logic                  ftb_hit;
      logic [FTB_IDX_W-1:0]  ftb_hit_index;
   } ftq_bpu_meta_t;

endpackage

// File: rtl/ftq_entry_ram.sv
// FTQ entry storage: 1 write port (P0/P1) and 2 combinational read ports (IFU issue, commit).
// Latency: write visible on reads the cycle after the write edge; reads are same-cycle.
// Backpressure: none; the owner guarantees legal indices.
// Ports: clk; i_wr_en/i_wr_idx/i_wr_blk/i_wr_meta write port; i_ifu_idx -> o_ifu_blk;
//        i_cm_idx -> o_cm_blk/o_cm_meta.
module ftq_entry_ram
   import ftq_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_idx,
   input  ftq_block_t    i_wr_blk,
   input  bpu_ftq_meta_t i_wr_meta,
   input  logic [AW-1:0] i_ifu_idx,
   output ftq_block_t    o_ifu_blk,
   input  logic [AW-1:0] i_cm_idx,
   output ftq_block_t    o_cm_blk,
   output bpu_ftq_meta_t o_cm_meta
);

   // Contents are never read before being written, so no reset.
   ftq_block_t    r_blk  [DEPTH];
   bpu_ftq_meta_t r_meta [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_blk[i_wr_idx]  <= i_wr_blk;
         r_meta[i_wr_idx] <= i_wr_meta;
      end
   end

   assign o_ifu_blk = r_blk[i_ifu_idx];
   assign o_cm_blk  = r_blk[i_cm_idx];
   assign o_cm_meta = r_meta[i_cm_idx];

endmodule

// File: rtl/ftq.sv
// Fetch Target Queue: buffers BPU blocks, issues them in order to the IFU, returns training on commit.
// Latency: P0 written in cycle N is visible to the IFU in N+1; training record registered 1 cycle after commit.
// Backpressure: ftq_full_o at occupancy >= DEPTH-1 (one slot absorbs an in-flight P0); IFU via ifu_ready_i.
// Ports: clk/rst_n; backend_flush_i; bpu_p0_i/bpu_p1_i/bpu_meta_i from BPU; ftq_full_o to BPU;
//        ifu_block_o/ifu_id_o/ifu_ready_i/ifu_flush_o to IFU; commit_valid_i/commit_info_i from backend;
//        bpu_train_o training record to BPU.
module ftq
   import ftq_pkg::ftq_block_t, ftq_pkg::bpu_ftq_meta_t, ftq_pkg::ftq_commit_t, ftq_pkg::ftq_bpu_meta_t;
#(
   parameter int unsigned FTQ_DEPTH = ftq_pkg::FTQ_DEPTH,
   parameter int unsigned ID_WIDTH  = $clog2(FTQ_DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                backend_flush_i,
   input  ftq_block_t          bpu_p0_i,
   input  ftq_block_t          bpu_p1_i,
   input  bpu_ftq_meta_t       bpu_meta_i,
   output logic                ftq_full_o,
   output ftq_block_t          ifu_block_o,
   output logic [ID_WIDTH-1:0] ifu_id_o,
   input  logic                ifu_ready_i,
   output logic                ifu_flush_o,
   input  logic                commit_valid_i,
   input  ftq_commit_t         commit_info_i,
   output ftq_bpu_meta_t       bpu_train_o
);

   // FTQ_DEPTH must be a power of two and at least 4 so the wrap-bit pointers work.
   localparam logic [ID_WIDTH:0] PTR_ONE  = (ID_WIDTH+1)'(1);
   localparam logic [ID_WIDTH:0] DEPTH_P  = (ID_WIDTH+1)'(FTQ_DEPTH);
   localparam logic [ID_WIDTH:0] DEPTH_M1 = (ID_WIDTH+1)'(FTQ_DEPTH - 1);

   logic [ID_WIDTH:0] r_bpu_ptr;
   logic [ID_WIDTH:0] r_ifu_ptr;
   logic [ID_WIDTH:0] r_comm_ptr;
   logic              r_last_wr_valid;
   ftq_bpu_meta_t     r_train;

   logic [ID_WIDTH:0] w_occ;
   logic [ID_WIDTH:0] w_bpu_ptr_m1;
   logic [ID_WIDTH:0] w_ifu_ptr_adv;
   logic [ID_WIDTH:0] w_comm_ptr_nxt;
   logic [ID_WIDTH:0] w_bpu_ptr_nxt;
   logic [ID_WIDTH:0] w_ifu_ptr_nxt;
   logic              w_ifu_vld;
   logic              w_ifu_fire;
   logic              w_commit;
   logic              w_p1_apply;
   logic              w_p0_wr;
   logic              w_rewind;

   logic              w_wr_en;
   logic [ID_WIDTH-1:0] w_wr_idx;
   ftq_block_t        w_wr_blk;
   bpu_ftq_meta_t     w_wr_meta;
   ftq_block_t        w_ifu_blk;
   ftq_block_t        w_cm_blk;
   bpu_ftq_meta_t     w_cm_meta;
   ftq_bpu_meta_t     w_train_nxt;
   logic              w_unused;

   // ---------------------------------------------------------------
   // Occupancy, handshakes and write decisions
   // ---------------------------------------------------------------
   assign w_occ        = r_bpu_ptr - r_comm_ptr;
   assign ftq_full_o   = (w_occ >= DEPTH_M1);

   assign w_ifu_vld    = (r_ifu_ptr != r_bpu_ptr);
   assign w_ifu_fire   = w_ifu_vld & ifu_ready_i;
   assign w_commit     = commit_valid_i & (r_comm_ptr != r_ifu_ptr);

   // P1 only means something when the block it overrides was written last cycle.
   assign w_p1_apply   = ~backend_flush_i & bpu_p1_i.valid & r_last_wr_valid;
   // The spare slot lets a P0 land after full was raised; only a truly full queue drops it.
   assign w_p0_wr      = ~backend_flush_i & ~w_p1_apply & bpu_p0_i.valid & (w_occ != DEPTH_P);

   assign w_bpu_ptr_m1   = r_bpu_ptr - PTR_ONE;
   assign w_ifu_ptr_adv  = w_ifu_fire ? (r_ifu_ptr + PTR_ONE) : r_ifu_ptr;
   assign w_comm_ptr_nxt = w_commit ? (r_comm_ptr + PTR_ONE) : r_comm_ptr;

   // The overridden entry has reached the IFU if the pointer (after this cycle's
   // handshake) sits at bpu_ptr: rewind so the corrected block is reissued.
   assign w_rewind     = w_p1_apply & (w_ifu_ptr_adv == r_bpu_ptr);
   assign ifu_flush_o  = backend_flush_i | w_rewind;

   always_comb begin
      w_bpu_ptr_nxt = r_bpu_ptr;
      w_ifu_ptr_nxt = w_ifu_ptr_adv;
      if (backend_flush_i) begin
         // Commit in the same cycle is honoured first, then everything younger is dropped.
         w_bpu_ptr_nxt = w_comm_ptr_nxt;
         w_ifu_ptr_nxt = w_comm_ptr_nxt;
      end else if (w_rewind) begin
         w_ifu_ptr_nxt = w_bpu_ptr_m1;
      end else if (w_p0_wr) begin
         w_bpu_ptr_nxt = r_bpu_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bpu_ptr       <= '0;
         r_ifu_ptr       <= '0;
         r_comm_ptr      <= '0;
         r_last_wr_valid <= 1'b0;
      end else begin
         r_bpu_ptr       <= w_bpu_ptr_nxt;
         r_ifu_ptr       <= w_ifu_ptr_nxt;
         r_comm_ptr      <= w_comm_ptr_nxt;
         r_last_wr_valid <= w_p0_wr;
      end
   end

   // ---------------------------------------------------------------
   // Entry storage: P1 rewrites the newest entry, P0 appends with cleared meta
   // ---------------------------------------------------------------
   assign w_wr_en   = w_p0_wr | w_p1_apply;
   assign w_wr_idx  = w_p1_apply ? w_bpu_ptr_m1[ID_WIDTH-1:0] : r_bpu_ptr[ID_WIDTH-1:0];
   assign w_wr_blk  = w_p1_apply ? bpu_p1_i : bpu_p0_i;
   assign w_wr_meta = w_p1_apply ? bpu_meta_i : '0;

   ftq_entry_ram #(
      .DEPTH (FTQ_DEPTH),
      .AW    (ID_WIDTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_blk  (w_wr_blk),
      .i_wr_meta (w_wr_meta),
      .i_ifu_idx (r_ifu_ptr[ID_WIDTH-1:0]),
      .o_ifu_blk (w_ifu_blk),
      .i_cm_idx  (r_comm_ptr[ID_WIDTH-1:0]),
      .o_cm_blk  (w_cm_blk),
      .o_cm_meta (w_cm_meta)
   );

   // ---------------------------------------------------------------
   // IFU output: zeroed when nothing is pending
   // ---------------------------------------------------------------
   always_comb begin
      ifu_block_o = '0;
      if (w_ifu_vld) begin
         ifu_block_o       = w_ifu_blk;
         ifu_block_o.valid = 1'b1;
      end
   end
   assign ifu_id_o = r_ifu_ptr[ID_WIDTH-1:0];

   // ---------------------------------------------------------------
   // Training record: entry + stored meta + resolved info, registered
   // ---------------------------------------------------------------
   always_comb begin
      w_train_nxt = '0;
      if (w_commit) begin
         w_train_nxt.valid                = 1'b1;
         w_train_nxt.start_pc             = w_cm_blk.start_pc;
         w_train_nxt.is_cross_cacheline   = w_cm_blk.is_cross_cacheline;
         w_train_nxt.predicted_taken      = w_cm_blk.predicted_taken;
         w_train_nxt.bpu_meta             = w_cm_meta.bpu_meta;
         w_train_nxt.is_taken             = commit_info_i.is_taken;
         w_train_nxt.branch_type          = commit_info_i.branch_type;
         w_train_nxt.jump_target_address  = commit_info_i.jump_target_address;
         w_train_nxt.fall_through_address = commit_info_i.fall_through_address;
         w_train_nxt.ftb_dirty            = commit_info_i.ftb_dirty;
         w_train_nxt.ftb_hit              = w_cm_meta.ftb_hit;
         w_train_nxt.ftb_hit_index        = w_cm_meta.ftb_hit_index;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_train <= '0;
      end else begin
         r_train <= w_train_nxt;
      end
   end
   assign bpu_train_o = r_train;

   // Block fields the training record does not carry.
   assign w_unused = ^{w_cm_blk.valid, w_cm_blk.length, w_cm_blk.predict_valid};

endmodule

// File: tb/tb_ftq.sv
`timescale 1ns/1ps
module tb_ftq;
   import ftq_pkg::*;

   localparam int DEPTH = FTQ_DEPTH;
   localparam int IDW   = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          backend_flush_i;
   ftq_block_t    bpu_p0_i;
   ftq_block_t    bpu_p1_i;
   bpu_ftq_meta_t bpu_meta_i;
   logic          ftq_full_o;
   ftq_block_t    ifu_block_o;
   logic [IDW-1:0] ifu_id_o;
   logic          ifu_ready_i;
   logic          ifu_flush_o;
   logic          commit_valid_i;
   ftq_commit_t   commit_info_i;
   ftq_bpu_meta_t bpu_train_o;

   ftq #(.FTQ_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .backend_flush_i (backend_flush_i),
      .bpu_p0_i        (bpu_p0_i),
      .bpu_p1_i        (bpu_p1_i),
      .bpu_meta_i      (bpu_meta_i),
      .ftq_full_o      (ftq_full_o),
      .ifu_block_o     (ifu_block_o),
      .ifu_id_o        (ifu_id_o),
      .ifu_ready_i     (ifu_ready_i),
      .ifu_flush_o     (ifu_flush_o),
      .commit_valid_i  (commit_valid_i),
      .commit_info_i   (commit_info_i),
      .bpu_train_o     (bpu_train_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model: a list of live blocks ----------------
   typedef struct packed {
      ftq_block_t    blk;
      bpu_ftq_meta_t meta;
   } ment_t;
   typedef struct packed {
      logic full;
      logic flush;
      logic ifu_vld;
      logic train_vld;
   } cyc_t;
   typedef struct packed {
      ftq_block_t     blk;
      logic [IDW-1:0] id;
   } ifu_exp_t;

   ment_t         m_ent[$];     // oldest uncommitted first
   int            m_iss;        // how many of m_ent the IFU has taken
   bit            m_lastwr;     // a P0 was stored last cycle
   int            m_comm;       // total commits since reset (gives entry ids)
   bit            m_train_pend;

   cyc_t          cyc_q[$];
   ifu_exp_t      ifu_q[$];
   ftq_bpu_meta_t train_q[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic ftq_block_t mk_blk(input logic [31:0] pc, input logic [3:0] len, input logic pv);
      ftq_block_t b;
      b = '0;
      b.valid              = 1'b1;
      b.start_pc           = pc;
      b.length             = len;
      b.predict_valid      = pv;
      b.predicted_taken    = pv;
      b.is_cross_cacheline = pc[4];
      return b;
   endfunction

   // Drive one cycle of inputs and advance the model across the coming edge.
   task automatic step(input ftq_block_t p0, input ftq_block_t p1, input bpu_ftq_meta_t m,
                       input logic rdy, input logic cv, input ftq_commit_t ci, input logic fl);
      cyc_t          c;
      int            sz;
      bit            fire, cmt;
      ment_t         e;
      ifu_exp_t      ie;
      ftq_bpu_meta_t t;
      @(posedge clk);
      #1;
      bpu_p0_i = p0; bpu_p1_i = p1; bpu_meta_i = m; ifu_ready_i = rdy;
      commit_valid_i = cv; commit_info_i = ci; backend_flush_i = fl;

      sz          = m_ent.size();
      c.full      = (sz >= DEPTH - 1);
      c.ifu_vld   = (m_iss < sz);
      c.train_vld = m_train_pend;
      c.flush     = 1'b0;
      fire        = c.ifu_vld && rdy;
      if (fire) begin
         ie.blk       = m_ent[m_iss].blk;
         ie.blk.valid = 1'b1;
         ie.id        = IDW'((m_comm + m_iss) % DEPTH);
         ifu_q.push_back(ie);
      end
      cmt = cv && (m_iss > 0);
      m_train_pend = cmt;
      if (cmt) begin
         t = '0;
         t.valid                = 1'b1;
         t.start_pc             = m_ent[0].blk.start_pc;
         t.is_cross_cacheline   = m_ent[0].blk.is_cross_cacheline;
         t.predicted_taken      = m_ent[0].blk.predicted_taken;
         t.bpu_meta             = m_ent[0].meta.bpu_meta;
         t.ftb_hit              = m_ent[0].meta.ftb_hit;
         t.ftb_hit_index        = m_ent[0].meta.ftb_hit_index;
         t.is_taken             = ci.is_taken;
         t.branch_type          = ci.branch_type;
         t.jump_target_address  = ci.jump_target_address;
         t.fall_through_address = ci.fall_through_address;
         t.ftb_dirty            = ci.ftb_dirty;
         train_q.push_back(t);
      end
      if (fl) begin
         c.flush = 1'b1;
         if (cmt) m_comm++;
         m_ent.delete();
         m_iss    = 0;
         m_lastwr = 0;
      end else begin
         if (fire) m_iss++;
         if (p1.valid && m_lastwr) begin
            e.blk = p1; e.meta = m;
            m_ent[sz-1] = e;
            if (m_iss == sz) begin
               m_iss   = sz - 1;
               c.flush = 1'b1;
            end
            m_lastwr = 0;
         end else if (p0.valid && sz < DEPTH) begin
            e.blk = p0; e.meta = '0;
            m_ent.push_back(e);
            m_lastwr = 1;
         end else begin
            m_lastwr = 0;
         end
         if (cmt) begin
            void'(m_ent.pop_front());
            m_iss--;
            m_comm++;
         end
      end
      cyc_q.push_back(c);
   endtask

   task automatic idle(input int n, input logic rdy, input logic cv);
      for (int k = 0; k < n; k++) step('0, '0, '0, rdy, cv, '0, 1'b0);
   endtask

   task automatic push_p0(input logic [31:0] pc, input logic rdy);
      step(mk_blk(pc, 4'd4, 1'b0), '0, '0, rdy, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      backend_flush_i = 1'b0; bpu_p0_i = '0; bpu_p1_i = '0; bpu_meta_i = '0;
      ifu_ready_i = 1'b0; commit_valid_i = 1'b0; commit_info_i = '0;
      m_ent.delete(); m_iss = 0; m_lastwr = 0; m_comm = 0; m_train_pend = 0;
      @(negedge clk);
      chk("rst_full", ftq_full_o, 1'b0);
      chk("rst_ifu_vld", ifu_block_o.valid, 1'b0);
      chk("rst_ifu_flush", ifu_flush_o, 1'b0);
      chk("rst_ifu_id", ifu_id_o, '0);
      chk("rst_train", bpu_train_o, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   cyc_t          mon_c;
   ifu_exp_t      mon_i;
   ftq_bpu_meta_t mon_t;
   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         mon_c = cyc_q.pop_front();
         chk("ftq_full", ftq_full_o, mon_c.full);
         chk("ifu_flush", ifu_flush_o, mon_c.flush);
         chk("ifu_vld", ifu_block_o.valid, mon_c.ifu_vld);
         chk("train_vld", bpu_train_o.valid, mon_c.train_vld);
      end
      if (rst_n && ifu_block_o.valid && ifu_ready_i) begin
         if (ifu_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ifu_unexpected: got block pc %h id %0d expected none", ifu_block_o.start_pc, ifu_id_o);
         end else begin
            mon_i = ifu_q.pop_front();
            chk("ifu_block", ifu_block_o, mon_i.blk);
            chk("ifu_id", ifu_id_o, mon_i.id);
         end
      end
      if (rst_n && bpu_train_o.valid) begin
         if (train_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL train_unexpected: got pc %h expected none", bpu_train_o.start_pc);
         end else begin
            mon_t = train_q.pop_front();
            chk("train_rec", bpu_train_o, mon_t);
         end
      end
   end

   // ---------------- stimulus ----------------
   ftq_commit_t   ci;
   bpu_ftq_meta_t mm;
   ftq_block_t    p0, p1;
   logic          rdy, cv, fl;

   initial begin
      rst_n = 1'b0;
      backend_flush_i = 1'b0; bpu_p0_i = '0; bpu_p1_i = '0; bpu_meta_i = '0;
      ifu_ready_i = 1'b0; commit_valid_i = 1'b0; commit_info_i = '0;

      // Three P0 blocks streamed straight to a ready IFU (ids 0,1,2).
      do_reset();
      push_p0(32'h1c00_0000, 1'b1);
      push_p0(32'h1c00_0010, 1'b1);
      push_p0(32'h1c00_0020, 1'b1);
      idle(2, 1'b1, 1'b0);
      // Commit entry 0 as taken to 0x1c000100, then the rest.
      ci = '0;
      ci.is_taken = 1'b1; ci.branch_type = BR_COND;
      ci.jump_target_address = 32'h1c00_0100; ci.fall_through_address = 32'h1c00_0010;
      step('0, '0, '0, 1'b1, 1'b1, ci, 1'b0);
      ci.is_taken = 1'b0; ci.ftb_dirty = 1'b1;
      step('0, '0, '0, 1'b1, 1'b1, ci, 1'b0);
      idle(3, 1'b1, 1'b1);

      // P1 override of a not-yet-issued block; the concurrent P0 is discarded.
      do_reset();
      mm = '0; mm.ftb_hit = 1'b1; mm.ftb_hit_index = 4'h5; mm.bpu_meta = 16'hbeef;
      push_p0(32'h1c00_0000, 1'b0);
      step(mk_blk(32'h1c00_0010, 4'd4, 1'b0), mk_blk(32'h1c00_0000, 4'd2, 1'b1), mm, 1'b0, 1'b0, '0, 1'b0);
      idle(3, 1'b1, 1'b0);
      idle(2, 1'b1, 1'b1);

      // Same override, but the IFU takes the stale block in the P1 cycle -> flush and reissue.
      do_reset();
      push_p0(32'h1c00_0000, 1'b0);
      step(mk_blk(32'h1c00_0010, 4'd4, 1'b0), mk_blk(32'h1c00_0000, 4'd2, 1'b1), mm, 1'b1, 1'b0, '0, 1'b0);
      idle(3, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b1);

      // Fill with IFU stalled: full at 7, the 8th lands, the 9th is dropped.
      do_reset();
      for (int k = 0; k < 9; k++) push_p0(32'h1c00_1000 + 32'(k * 16), 1'b0);
      idle(12, 1'b1, 1'b1);

      // Five entries, two issued, flush together with a commit.
      do_reset();
      for (int k = 0; k < 5; k++) push_p0(32'h1c00_2000 + 32'(k * 16), 1'b0);
      idle(2, 1'b1, 1'b0);
      step('0, '0, '0, 1'b1, 1'b1, ci, 1'b1);
      idle(1, 1'b1, 1'b0);
      push_p0(32'h1c00_3000, 1'b1);
      idle(2, 1'b1, 1'b1);

      // Randomised traffic, long enough for the pointers to wrap many times.
      for (int i = 0; i < 800; i++) begin
         p0 = '0; p1 = '0; cv = 1'b0;
         if ($urandom_range(0, 99) < 60)
            p0 = mk_blk(32'h1c00_0000 + 32'(i * 16), 4'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
         mm.ftb_hit       = 1'($urandom_range(0, 1));
         mm.ftb_hit_index = 4'($urandom_range(0, 15));
         mm.bpu_meta      = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 99) < 15)
            p1 = mk_blk(32'h1d00_0000 + 32'(i * 16), 4'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
         else
            cv = ($urandom_range(0, 99) < 45);
         ci.is_taken             = 1'($urandom_range(0, 1));
         ci.branch_type          = branch_type_e'($urandom_range(0, 3));
         ci.jump_target_address  = $urandom;
         ci.fall_through_address = $urandom;
         ci.ftb_dirty            = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 99) < 60);
         fl  = ($urandom_range(0, 99) < 3);
         step(p0, p1, mm, rdy, cv, ci, fl);
      end
      idle(3, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      chk("ifu_q_drained", 32'(ifu_q.size()), 32'd0);
      chk("train_q_drained", 32'(train_q.size()), 32'd0);
      chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
